// File: rtl/history_sched.sv
// history_sched: one shared bit-history evaluator time-multiplexed over N_CH serial requesters.
// Round-robin grant, per-channel context writeback, registered match flags tagged with channel.
module history_ctx (
    input  logic       clk,
    input  logic       reset,
    input  logic       clr,
    input  logic       we,
    input  logic [2:0] nxt,
    output logic [2:0] state
);
    // 3'd0 is the NONE (no history) encoding
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)   state <= 3'd0;
        else if (clr) state <= 3'd0;
        else if (we)  state <= nxt;
    end
endmodule

module history_sched #(
    parameter  int N_CH = 4,
    localparam int CW   = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] req_valid,
    input  logic [N_CH-1:0] req_bit,
    output logic [N_CH-1:0] req_ready,
    input  logic [N_CH-1:0] ch_clr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [CW-1:0]   out_ch,
    output logic            out_x,
    output logic            out_y
);
    typedef enum logic [2:0] {NONE = 3'd0, Z1, ZN, O1, ON} hist_t;

    logic [N_CH-1:0][2:0] ctx;
    logic [N_CH-1:0]      elig, grant;
    logic [CW-1:0]        last_grant, gidx;
    logic                 stall, accept, found, b, fx, fy;
    hist_t                cur, nxt;

    assign stall = out_valid & ~out_ready;
    assign elig  = req_valid & ~ch_clr;

    // Search starts one past the last grant and wraps; reset gates grants off.
    always_comb begin
        grant = '0;
        gidx  = '0;
        found = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            if (!found && elig[(int'(last_grant) + k) % N_CH]) begin
                found = 1'b1;
                gidx  = CW'((int'(last_grant) + k) % N_CH);
            end
        end
        if (found && !stall && reset) grant[gidx] = 1'b1;
    end

    assign req_ready = grant;
    assign accept    = |grant;

    assign b   = req_bit[gidx];
    assign cur = hist_t'(ctx[gidx]);

    always_comb begin
        nxt = b ? O1 : Z1;
        fx  = 1'b0;
        fy  = 1'b0;
        case (cur)
            Z1: if (!b) begin nxt = ZN; fx = 1'b1; end
            ZN: if (!b) begin nxt = ZN; fx = 1'b1; fy = 1'b1; end
            O1: if (b)  begin nxt = ON; fx = 1'b1; end
            ON: if (b)  begin nxt = ON; fx = 1'b1; fy = 1'b1; end
            default: ;
        endcase
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ctx
        history_ctx u_ctx (
            .clk   (clk),
            .reset (reset),
            .clr   (ch_clr[i]),
            .we    (grant[i]),
            .nxt   (nxt),
            .state (ctx[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant <= CW'(N_CH - 1);
            out_valid  <= 1'b0;
            out_ch     <= '0;
            out_x      <= 1'b0;
            out_y      <= 1'b0;
        end else if (accept) begin
            last_grant <= gidx;
            out_valid  <= 1'b1;
            out_ch     <= gidx;
            out_x      <= fx;
            out_y      <= fy;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end
endmodule
